// File: rtl/seq_fetch_decode_execute_if.sv
// Bus between the SEQ front half and its environment.
//   master side drives : pc, instr, regs
//   slave side drives  : icode, ifun, rA, rB, valC, valP, instr_err, mem_error,
//                        valA, valB, valE, cnd, cc, cf_out
interface seq_fetch_decode_execute_if;
   logic [63:0]  pc;
   logic [79:0]  instr;
   logic [959:0] regs;
   logic [3:0]   icode;
   logic [3:0]   ifun;
   logic [3:0]   rA;
   logic [3:0]   rB;
   logic [63:0]  valC;
   logic [63:0]  valP;
   logic         instr_err;
   logic         mem_error;
   logic [63:0]  valA;
   logic [63:0]  valB;
   logic [63:0]  valE;
   logic         cnd;
   logic [2:0]   cc;
   logic [2:0]   cf_out;

   modport master (
      output pc, instr, regs,
      input  icode, ifun, rA, rB, valC, valP, instr_err, mem_error,
             valA, valB, valE, cnd, cc, cf_out
   );

   modport slave (
      input  pc, instr, regs,
      output icode, ifun, rA, rB, valC, valP, instr_err, mem_error,
             valA, valB, valE, cnd, cc, cf_out
   );
endinterface

// File: rtl/seq_fetch_decode_execute.sv
// Fetch / decode / execute front half of the single-cycle Y86-64 SEQ core.
// Everything is combinational from bus.pc, bus.instr, bus.regs and the CC
// register; the 3-bit CC register {ZF,SF,OF} is the only state.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset, clears CC only
//   bus  - slave side of seq_fetch_decode_execute_if (instruction window,
//          register file image in; decoded fields, operands, ALU result,
//          condition and flags out)
module seq_fetch_decode_execute #(
   parameter int unsigned IMEM_BYTES = 1024
) (
   input  logic                          clk,
   input  logic                          rst,
   seq_fetch_decode_execute_if.slave     bus
);

   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_RRMOVQ = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;
   localparam logic [3:0] R_RSP    = 4'h4;
   localparam logic [3:0] R_NONE   = 4'hF;

   // Last PC whose full 10-byte window still fits in instruction memory.
   localparam logic [63:0] PC_LIMIT = 64'(IMEM_BYTES - 10);

   logic [3:0]  icode, ifun, ra, rb, src_a, src_b;
   logic [63:0] val_c, val_p, ilen, val_a, val_b, val_e;
   logic [63:0] sum, diff;
   logic        instr_err, mem_error, cnd;
   logic [2:0]  cf;
   logic [2:0]  cc_d, cc_q;
   logic        zf, sf, of_f;

   // Register file as an array; slot 15 is the "no register" source and reads 0.
   logic [63:0] rf [16];

   for (genvar gi = 0; gi < 15; gi++) begin : g_rf
      assign rf[gi] = bus.regs[64*gi +: 64];
   end
   assign rf[15] = '0;

   // ---------------- fetch ----------------
   always_comb begin
      icode     = bus.instr[79:76];
      ifun      = bus.instr[75:72];
      instr_err = (icode > I_POPQ);
      mem_error = (bus.pc > PC_LIMIT);
      ra        = R_NONE;
      rb        = R_NONE;
      val_c     = '0;
      ilen      = 64'd1;
      case (icode)
         I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: begin
            ra   = bus.instr[71:68];
            rb   = bus.instr[67:64];
            ilen = 64'd2;
         end
         I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
            ra    = bus.instr[71:68];
            rb    = bus.instr[67:64];
            val_c = bus.instr[63:0];
            ilen  = 64'd10;
         end
         I_JXX, I_CALL: begin
            // no register byte, constant follows the opcode directly
            val_c = bus.instr[71:8];
            ilen  = 64'd9;
         end
         default: ;
      endcase
      val_p = bus.pc + ilen;
   end

   // ---------------- decode ----------------
   always_comb begin
      src_a = R_NONE;
      src_b = R_NONE;
      case (icode)
         I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ: src_a = ra;
         I_RET, I_POPQ:                      src_a = R_RSP;
         default: ;
      endcase
      case (icode)
         I_RMMOVQ, I_MRMOVQ, I_OPQ:          src_b = rb;
         I_CALL, I_RET, I_PUSHQ, I_POPQ:     src_b = R_RSP;
         default: ;
      endcase
      val_a = rf[src_a];
      val_b = rf[src_b];
   end

   // ---------------- execute ----------------
   assign sum  = val_b + val_a;
   assign diff = val_b - val_a;

   always_comb begin
      val_e = '0;
      case (icode)
         I_RRMOVQ:           val_e = val_a;
         I_IRMOVQ:           val_e = val_c;
         I_RMMOVQ, I_MRMOVQ: val_e = val_b + val_c;
         I_OPQ: begin
            case (ifun)
               4'h0:    val_e = sum;
               4'h1:    val_e = diff;
               4'h2:    val_e = val_b & val_a;
               4'h3:    val_e = val_b ^ val_a;
               default: val_e = '0;
            endcase
         end
         I_CALL, I_PUSHQ:    val_e = val_b - 64'd8;
         I_RET, I_POPQ:      val_e = val_b + 64'd8;
         default: ;
      endcase
   end

   // Flags only mean something for OPq; other instructions report 000.
   always_comb begin
      cf = 3'b000;
      if (icode == I_OPQ) begin
         cf[2] = (val_e == 64'd0);
         cf[1] = val_e[63];
         case (ifun)
            4'h0:    cf[0] = (val_a[63] == val_b[63]) && (val_e[63] != val_b[63]);
            4'h1:    cf[0] = (val_a[63] != val_b[63]) && (val_e[63] != val_b[63]);
            default: cf[0] = 1'b0;
         endcase
      end
   end

   // Conditions are judged against the stored CC, not this cycle's flags.
   assign zf   = cc_q[2];
   assign sf   = cc_q[1];
   assign of_f = cc_q[0];

   always_comb begin
      cnd = 1'b0;
      if (icode == I_RRMOVQ || icode == I_JXX) begin
         case (ifun)
            4'h0:    cnd = 1'b1;
            4'h1:    cnd = (sf ^ of_f) | zf;
            4'h2:    cnd = sf ^ of_f;
            4'h3:    cnd = zf;
            4'h4:    cnd = ~zf;
            4'h5:    cnd = ~(sf ^ of_f);
            4'h6:    cnd = ~(sf ^ of_f) & ~zf;
            default: cnd = 1'b0;
         endcase
      end
   end

   // ---------------- CC register ----------------
   always_comb begin
      cc_d = cc_q;
      if (icode == I_OPQ && ifun <= 4'h3 && !instr_err && !mem_error)
         cc_d = cf;
   end

   always_ff @(posedge clk) begin
      if (rst) cc_q <= 3'b000;
      else     cc_q <= cc_d;
   end

   assign bus.icode     = icode;
   assign bus.ifun      = ifun;
   assign bus.rA        = ra;
   assign bus.rB        = rb;
   assign bus.valC      = val_c;
   assign bus.valP      = val_p;
   assign bus.instr_err = instr_err;
   assign bus.mem_error = mem_error;
   assign bus.valA      = val_a;
   assign bus.valB      = val_b;
   assign bus.valE      = val_e;
   assign bus.cnd       = cnd;
   assign bus.cc        = cc_q;
   assign bus.cf_out    = cf;

endmodule

// File: tb/tb_seq_fetch_decode_execute.sv
// Bench for seq_fetch_decode_execute: directed vector table, hand-written
// CC sequences, and random instructions against a byte-level reference model.
module tb_seq_fetch_decode_execute;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   seq_fetch_decode_execute_if bus ();

   seq_fetch_decode_execute #(.IMEM_BYTES(1024)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [3:0]  icode, ifun, ra, rb;
      logic [63:0] valc, valp, vala, valb, vale;
      logic        cnd, ierr, merr;
      logic [2:0]  cf;
   } res_t;

   typedef struct {
      logic [63:0] pc;
      logic [79:0] instr;
      res_t        exp;
   } vec_t;

   int          n_cmp  = 0;
   int          n_fail = 0;
   logic [63:0] rm [15];
   logic [2:0]  cc_m;
   vec_t        tbl [17];

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic load_regs();
      for (int i = 0; i < 15; i++) bus.regs[64*i +: 64] = rm[i];
   endtask

   task automatic base_regs();
      for (int i = 0; i < 15; i++) rm[i] = 64'h100 + 64'(i);
      rm[2] = 64'd2;
      rm[3] = 64'd3;
      rm[4] = 64'd60;
   endtask

   task automatic apply(input logic [63:0] pc, input logic [79:0] ins);
      bus.pc    = pc;
      bus.instr = ins;
      load_regs();
      #2;
   endtask

   // Reference model: decodes from the instruction bytes and Y86 rules.
   function automatic res_t model(input logic [63:0] pc, input logic [79:0] ins, input logic [2:0] ccv);
      res_t       r;
      logic [7:0] b [10];
      int         lens [16];
      int         sa, sb;
      logic       zf, sf, ofl;
      lens = '{1, 1, 2, 10, 10, 10, 2, 9, 9, 1, 2, 2, 1, 1, 1, 1};
      for (int k = 0; k < 10; k++) b[k] = ins[79-8*k -: 8];
      r = '{default: '0};
      r.icode = b[0][7:4];
      r.ifun  = b[0][3:0];
      r.ierr  = (r.icode > 4'd11);
      r.merr  = (pc > 64'd1014);
      r.ra    = 4'hF;
      r.rb    = 4'hF;
      if (r.icode inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB}) begin
         r.ra = b[1][7:4];
         r.rb = b[1][3:0];
      end
      if (r.icode inside {4'h3, 4'h4, 4'h5})
         for (int k = 2; k < 10; k++) r.valc = (r.valc << 8) | 64'(b[k]);
      if (r.icode inside {4'h7, 4'h8})
         for (int k = 1; k < 9; k++) r.valc = (r.valc << 8) | 64'(b[k]);
      r.valp = pc + 64'(lens[r.icode]);
      sa = 15;
      sb = 15;
      if (r.icode inside {4'h2, 4'h4, 4'h6, 4'hA}) sa = int'(r.ra);
      if (r.icode inside {4'h9, 4'hB})             sa = 4;
      if (r.icode inside {4'h4, 4'h5, 4'h6})       sb = int'(r.rb);
      if (r.icode inside {4'h8, 4'h9, 4'hA, 4'hB}) sb = 4;
      r.vala = (sa == 15) ? 64'd0 : rm[sa];
      r.valb = (sb == 15) ? 64'd0 : rm[sb];
      case (r.icode)
         4'h2: r.vale = r.vala;
         4'h3: r.vale = r.valc;
         4'h4, 4'h5: r.vale = r.valb + r.valc;
         4'h6: begin
            if (r.ifun == 0)      r.vale = r.valb + r.vala;
            else if (r.ifun == 1) r.vale = r.valb - r.vala;
            else if (r.ifun == 2) r.vale = r.valb & r.vala;
            else if (r.ifun == 3) r.vale = r.valb ^ r.vala;
            else                  r.vale = 64'd0;
            ofl = 1'b0;
            if (r.ifun == 0) ofl = (r.vala[63] == r.valb[63]) && (r.vale[63] != r.valb[63]);
            if (r.ifun == 1) ofl = (r.vala[63] != r.valb[63]) && (r.vale[63] != r.valb[63]);
            r.cf = {r.vale == 64'd0, r.vale[63], ofl};
         end
         4'h8, 4'hA: r.vale = r.valb - 64'd8;
         4'h9, 4'hB: r.vale = r.valb + 64'd8;
         default: r.vale = 64'd0;
      endcase
      zf = ccv[2]; sf = ccv[1]; ofl = ccv[0];
      if (r.icode == 4'h2 || r.icode == 4'h7) begin
         case (r.ifun)
            4'd0: r.cnd = 1'b1;
            4'd1: r.cnd = (sf != ofl) || zf;
            4'd2: r.cnd = (sf != ofl);
            4'd3: r.cnd = zf;
            4'd4: r.cnd = !zf;
            4'd5: r.cnd = (sf == ofl);
            4'd6: r.cnd = (sf == ofl) && !zf;
            default: r.cnd = 1'b0;
         endcase
      end
      return r;
   endfunction

   task automatic tick();
      res_t e;
      e = model(bus.pc, bus.instr, cc_m);
      @(posedge clk);
      if (rst) cc_m = 3'b000;
      else if (e.icode == 4'h6 && e.ifun <= 4'd3 && !e.ierr && !e.merr) cc_m = e.cf;
      #1;
   endtask

   task automatic compare_all(input string tag, input res_t e);
      check({tag, ".icode"}, 64'(bus.icode), 64'(e.icode));
      check({tag, ".ifun"},  64'(bus.ifun),  64'(e.ifun));
      check({tag, ".rA"},    64'(bus.rA),    64'(e.ra));
      check({tag, ".rB"},    64'(bus.rB),    64'(e.rb));
      check({tag, ".valC"},  bus.valC, e.valc);
      check({tag, ".valP"},  bus.valP, e.valp);
      check({tag, ".valA"},  bus.valA, e.vala);
      check({tag, ".valB"},  bus.valB, e.valb);
      check({tag, ".valE"},  bus.valE, e.vale);
      check({tag, ".cnd"},   64'(bus.cnd),       64'(e.cnd));
      check({tag, ".ierr"},  64'(bus.instr_err), 64'(e.ierr));
      check({tag, ".merr"},  64'(bus.mem_error), 64'(e.merr));
      check({tag, ".cf"},    64'(bus.cf_out),    64'(e.cf));
   endtask

   initial begin
      // {icode, ifun, rA, rB, valC, valP, valA, valB, valE, cnd, ierr, merr, cf} with cc = 000
      tbl[0]  = '{64'd3,    80'h30020000000000000011, '{4'h3,4'h0,4'h0,4'h2,64'h11,64'd13,64'd0,64'd0,64'h11,1'b0,1'b0,1'b0,3'b000}};
      tbl[1]  = '{64'd0,    80'h60230000000000000000, '{4'h6,4'h0,4'h2,4'h3,64'd0,64'd2,64'd2,64'd3,64'd5,1'b0,1'b0,1'b0,3'b000}};
      tbl[2]  = '{64'd0,    80'hA05F0000000000000000, '{4'hA,4'h0,4'h5,4'hF,64'd0,64'd2,64'h105,64'd60,64'd52,1'b0,1'b0,1'b0,3'b000}};
      tbl[3]  = '{64'd0,    80'hB03F0000000000000000, '{4'hB,4'h0,4'h3,4'hF,64'd0,64'd2,64'd60,64'd60,64'd68,1'b0,1'b0,1'b0,3'b000}};
      tbl[4]  = '{64'h20,   80'h80000000000000010000, '{4'h8,4'h0,4'hF,4'hF,64'h100,64'h29,64'd0,64'd60,64'd52,1'b0,1'b0,1'b0,3'b000}};
      tbl[5]  = '{64'h40,   80'h90000000000000000000, '{4'h9,4'h0,4'hF,4'hF,64'd0,64'h41,64'd60,64'd60,64'd68,1'b0,1'b0,1'b0,3'b000}};
      tbl[6]  = '{64'h10,   80'hC0123456789ABCDEF012, '{4'hC,4'h0,4'hF,4'hF,64'd0,64'h11,64'd0,64'd0,64'd0,1'b0,1'b1,1'b0,3'b000}};
      tbl[7]  = '{64'd1020, 80'h60230000000000000000, '{4'h6,4'h0,4'h2,4'h3,64'd0,64'd1022,64'd2,64'd3,64'd5,1'b0,1'b0,1'b1,3'b000}};
      tbl[8]  = '{64'd1014, 80'h10000000000000000000, '{4'h1,4'h0,4'hF,4'hF,64'd0,64'd1015,64'd0,64'd0,64'd0,1'b0,1'b0,1'b0,3'b000}};
      tbl[9]  = '{64'd1015, 80'h10000000000000000000, '{4'h1,4'h0,4'hF,4'hF,64'd0,64'd1016,64'd0,64'd0,64'd0,1'b0,1'b0,1'b1,3'b000}};
      tbl[10] = '{64'd0,    80'h23530000000000000000, '{4'h2,4'h3,4'h5,4'h3,64'd0,64'd2,64'h105,64'd0,64'h105,1'b0,1'b0,1'b0,3'b000}};
      tbl[11] = '{64'h100,  80'h70000000000000123400, '{4'h7,4'h0,4'hF,4'hF,64'h1234,64'h109,64'd0,64'd0,64'd0,1'b1,1'b0,1'b0,3'b000}};
      tbl[12] = '{64'd0,    80'h50320000000000000010, '{4'h5,4'h0,4'h3,4'h2,64'h10,64'd10,64'd0,64'd2,64'h12,1'b0,1'b0,1'b0,3'b000}};
      tbl[13] = '{64'd0,    80'h40230000000000000008, '{4'h4,4'h0,4'h2,4'h3,64'd8,64'd10,64'd2,64'd3,64'd11,1'b0,1'b0,1'b0,3'b000}};
      tbl[14] = '{64'd0,    80'h61320000000000000000, '{4'h6,4'h1,4'h3,4'h2,64'd0,64'd2,64'd3,64'd2,64'hFFFFFFFFFFFFFFFF,1'b0,1'b0,1'b0,3'b010}};
      tbl[15] = '{64'd0,    80'h63220000000000000000, '{4'h6,4'h3,4'h2,4'h2,64'd0,64'd2,64'd2,64'd2,64'd0,1'b0,1'b0,1'b0,3'b100}};
      tbl[16] = '{64'd0,    80'h30F20123456789ABCDEF, '{4'h3,4'h0,4'hF,4'h2,64'h0123456789ABCDEF,64'd10,64'd0,64'd0,64'h0123456789ABCDEF,1'b0,1'b0,1'b0,3'b000}};

      // ---- reset ----
      rst  = 1'b1;
      cc_m = 3'b000;
      base_regs();
      apply(64'd0, 80'h0);
      tick();
      tick();
      check("reset.cc", 64'(bus.cc), 64'd0);

      // ---- table, held in reset so cc stays 000 ----
      for (int i = 0; i < 17; i++) begin
         apply(tbl[i].pc, tbl[i].instr);
         compare_all($sformatf("vec%0d", i), tbl[i].exp);
         tick();
         check($sformatf("vec%0d.cc", i), 64'(bus.cc), 64'd0);
      end
      rst = 1'b0;

      // ---- sub to zero, then cmove / cmovne ----
      base_regs();
      rm[2] = 64'd7; rm[3] = 64'd7;
      apply(64'd0, 80'h61230000000000000000);
      check("subz.valE", bus.valE, 64'd0);
      check("subz.cf",   64'(bus.cf_out), 64'b100);
      tick();
      check("subz.cc",   64'(bus.cc), 64'b100);
      apply(64'd0, 80'h23530000000000000000);
      check("cmove.cnd", 64'(bus.cnd), 64'd1);
      apply(64'd0, 80'h24530000000000000000);
      check("cmovne.cnd", 64'(bus.cnd), 64'd0);

      // ---- signed overflow on sub ----
      rm[3] = 64'h8000000000000000; rm[2] = 64'd1;
      apply(64'd0, 80'h61230000000000000000);
      check("ovf.valE", bus.valE, 64'h7FFFFFFFFFFFFFFF);
      check("ovf.cf",   64'(bus.cf_out), 64'b001);
      tick();
      check("ovf.cc",   64'(bus.cc), 64'b001);
      apply(64'd0, 80'h22530000000000000000);
      check("cmovl.cnd", 64'(bus.cnd), 64'd1);
      apply(64'd0, 80'h25530000000000000000);
      check("cmovge.cnd", 64'(bus.cnd), 64'd0);

      // ---- out-of-range PC blocks the CC update ----
      rm[2] = 64'd0; rm[3] = 64'd0;
      apply(64'd1020, 80'h60230000000000000000);
      check("merr.flag", 64'(bus.mem_error), 64'd1);
      check("merr.cf",   64'(bus.cf_out), 64'b100);
      tick();
      check("merr.cc",   64'(bus.cc), 64'b001);

      // ---- synchronous reset clears CC ----
      apply(64'd0, 80'h61230000000000000000);
      tick();
      check("prerst.cc", 64'(bus.cc), 64'b100);
      rst = 1'b1;
      tick();
      check("rst.cc", 64'(bus.cc), 64'b000);
      rst = 1'b0;
      cc_m = 3'b000;

      // ---- random instructions vs. reference model ----
      for (int it = 0; it < 400; it++) begin
         logic [79:0] ins;
         logic [63:0] pc;
         logic [3:0]  ic, fn;
         res_t        e;
         for (int i = 0; i < 15; i++) begin
            case ($urandom_range(0, 3))
               0: rm[i] = 64'h8000000000000000;
               1: rm[i] = 64'h7FFFFFFFFFFFFFFF - 64'($urandom_range(0, 3));
               2: rm[i] = 64'($urandom_range(0, 20));
               default: rm[i] = {$urandom, $urandom};
            endcase
         end
         ic  = 4'($urandom_range(0, 15));
         fn  = (ic == 4'h6) ? 4'($urandom_range(0, 4)) : 4'($urandom_range(0, 8));
         ins = {$urandom, $urandom, 16'($urandom)};
         ins[79:72] = {ic, fn};
         if ($urandom_range(0, 3) == 0) ins[71:68] = 4'hF;
         case ($urandom_range(0, 5))
            0: pc = 64'($urandom_range(1005, 1040));
            1: pc = {$urandom, $urandom};
            default: pc = 64'($urandom_range(0, 1013));
         endcase
         rst = ($urandom_range(0, 19) == 0);
         apply(pc, ins);
         e = model(pc, ins, cc_m);
         compare_all($sformatf("rnd%0d", it), e);
         tick();
         check($sformatf("rnd%0d.cc", it), 64'(bus.cc), 64'(cc_m));
      end
      rst = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
